// File: rtl/microwave_timekeeper_pkg.sv
// Shared types and constants for the microwave time-of-day / cook-timer controller.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_CLOCK = 3'd0,
    ST_SET   = 3'd1,
    ST_ENTRY = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int   SEC_MAX  = 59;
  localparam int   MIN_MAX  = 59;
  localparam bcd_t BCD_NINE = 4'd9;

  // Tens-digit limits used by the per-digit counters and entry validation.
  localparam bcd_t SEC_TENS_MAX = bcd_t'(SEC_MAX / 10);
  localparam bcd_t MIN_TENS_MAX = bcd_t'(MIN_MAX / 10);

endpackage

// File: rtl/microwave_timekeeper_bcd_digit_counter.sv
// One BCD digit with wrap at MAXV; carry/borrow flag the wrap of an inc/dec.
module bcd_digit_counter import microwave_pkg::*; #(
  parameter bcd_t MAXV = BCD_NINE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t q,
  output bcd_t nxt,
  output logic carry,
  output logic borrow
);

  assign carry  = inc && (q == MAXV);
  assign borrow = dec && (q == 4'd0);

  // nxt is exported so the parent can register outputs in the same cycle.
  always_comb begin
    nxt = q;
    if (load)     nxt = load_val;
    else if (inc) nxt = carry  ? 4'd0 : q + 4'd1;
    else if (dec) nxt = borrow ? MAXV : q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 4'd0;
    else        q <= nxt;
  end

endmodule

// File: rtl/microwave_timekeeper.sv
// Microwave front panel: BCD time of day with keypad set, MM:SS cook countdown,
// four registered display digits with blink enables.
module microwave_timekeeper import microwave_pkg::*; #(
  parameter int TICK_DIV  = 1000,
  parameter int BLINK_DIV = 250,
  parameter int MAX_HOUR  = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        cancel,
  input  logic        conf,
  output logic [15:0] disp,
  output logic [3:0]  disp_en,
  output logic [2:0]  state_o,
  output logic        running,
  output logic        done
);

  localparam int   TW     = (TICK_DIV > 1)  ? $clog2(TICK_DIV)  : 1;
  localparam int   BW     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam bcd_t MAXH_T = bcd_t'(MAX_HOUR / 10);
  localparam bcd_t MAXH_U = bcd_t'(MAX_HOUR % 10);
  localparam bcd_t WRAP_U = (MAX_HOUR == 12) ? 4'd1 : 4'd0;

  // Strobes are single-cycle pulses with no back-pressure: each is acted on
  // in the cycle it is high, lower-priority strobes in that cycle are dropped.
  state_t      state, state_nxt;
  logic [15:0] entry_buf, buf_nxt;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic        blink_ph, blink_nxt, tick;
  logic        tod_inc, tod_load, hour_wrap, cd_load, run_dec;
  logic        key_ok, set_ok, entry_ok, cd_one, blink_st;
  logic [15:0] disp_nxt;

  bcd_t sec_u_q, sec_u_n, sec_t_q, sec_t_n, mn_u_q, mn_u_n, mn_t_q, mn_t_n;
  bcd_t hr_u_q, hr_u_n, hr_t_q, hr_t_n;
  bcd_t ss_u_q, ss_u_n, ss_t_q, ss_t_n, mm_u_q, mm_u_n, mm_t_q, mm_t_n;
  logic sec_u_c, sec_t_c, mn_u_c, mn_t_c, hr_u_c, hr_t_c;
  logic sec_u_b, sec_t_b, mn_u_b, mn_t_b, hr_u_b, hr_t_b;
  logic ss_u_c, ss_t_c, mm_u_c, mm_t_c, ss_u_b, ss_t_b, mm_u_b, mm_t_b;

  assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
  assign blink_nxt = blink_ph ^ (blink_cnt == BW'(BLINK_DIV - 1));
  assign key_ok    = key_valid && (key_digit <= BCD_NINE);
  assign tod_inc   = tick && (state != ST_SET);
  assign hour_wrap = mn_t_c && (hr_t_q == MAXH_T) && (hr_u_q == MAXH_U);
  assign set_ok    = ((entry_buf[15:12] < MAXH_T) ||
                      ((entry_buf[15:12] == MAXH_T) && (entry_buf[11:8] <= MAXH_U))) &&
                     (entry_buf[7:4] <= MIN_TENS_MAX);
  assign entry_ok  = (entry_buf[7:4] <= SEC_TENS_MAX) && (entry_buf != 16'h0000);
  assign cd_one    = ({mm_t_q, mm_u_q, ss_t_q, ss_u_q} == 16'h0001);
  assign state_o   = state;

  // Time of day: seconds are kept in BCD too, so every digit is one counter.
  bcd_digit_counter #(.MAXV(BCD_NINE)) u_sec_u (
    .clk(clk), .rst_n(rst_n), .inc(tod_inc), .dec(1'b0), .load(tod_load), .load_val(4'd0),
    .q(sec_u_q), .nxt(sec_u_n), .carry(sec_u_c), .borrow(sec_u_b));
  bcd_digit_counter #(.MAXV(SEC_TENS_MAX)) u_sec_t (
    .clk(clk), .rst_n(rst_n), .inc(sec_u_c), .dec(1'b0), .load(tod_load), .load_val(4'd0),
    .q(sec_t_q), .nxt(sec_t_n), .carry(sec_t_c), .borrow(sec_t_b));
  bcd_digit_counter #(.MAXV(BCD_NINE)) u_mn_u (
    .clk(clk), .rst_n(rst_n), .inc(sec_t_c), .dec(1'b0), .load(tod_load),
    .load_val(entry_buf[3:0]),
    .q(mn_u_q), .nxt(mn_u_n), .carry(mn_u_c), .borrow(mn_u_b));
  bcd_digit_counter #(.MAXV(MIN_TENS_MAX)) u_mn_t (
    .clk(clk), .rst_n(rst_n), .inc(mn_u_c), .dec(1'b0), .load(tod_load),
    .load_val(entry_buf[7:4]),
    .q(mn_t_q), .nxt(mn_t_n), .carry(mn_t_c), .borrow(mn_t_b));
  // Hour wrap is a load that overrides the normal increment.
  bcd_digit_counter #(.MAXV(BCD_NINE)) u_hr_u (
    .clk(clk), .rst_n(rst_n), .inc(mn_t_c), .dec(1'b0), .load(tod_load || hour_wrap),
    .load_val(tod_load ? entry_buf[11:8] : WRAP_U),
    .q(hr_u_q), .nxt(hr_u_n), .carry(hr_u_c), .borrow(hr_u_b));
  bcd_digit_counter #(.MAXV(MAXH_T)) u_hr_t (
    .clk(clk), .rst_n(rst_n), .inc(hr_u_c), .dec(1'b0), .load(tod_load || hour_wrap),
    .load_val(tod_load ? entry_buf[15:12] : 4'd0),
    .q(hr_t_q), .nxt(hr_t_n), .carry(hr_t_c), .borrow(hr_t_b));

  // Cook countdown MM:SS, minutes tens allowed up to 9.
  bcd_digit_counter #(.MAXV(BCD_NINE)) u_ss_u (
    .clk(clk), .rst_n(rst_n), .inc(1'b0), .dec(run_dec), .load(cd_load),
    .load_val(entry_buf[3:0]),
    .q(ss_u_q), .nxt(ss_u_n), .carry(ss_u_c), .borrow(ss_u_b));
  bcd_digit_counter #(.MAXV(SEC_TENS_MAX)) u_ss_t (
    .clk(clk), .rst_n(rst_n), .inc(1'b0), .dec(ss_u_b), .load(cd_load),
    .load_val(entry_buf[7:4]),
    .q(ss_t_q), .nxt(ss_t_n), .carry(ss_t_c), .borrow(ss_t_b));
  bcd_digit_counter #(.MAXV(BCD_NINE)) u_mm_u (
    .clk(clk), .rst_n(rst_n), .inc(1'b0), .dec(ss_t_b), .load(cd_load),
    .load_val(entry_buf[11:8]),
    .q(mm_u_q), .nxt(mm_u_n), .carry(mm_u_c), .borrow(mm_u_b));
  bcd_digit_counter #(.MAXV(BCD_NINE)) u_mm_t (
    .clk(clk), .rst_n(rst_n), .inc(1'b0), .dec(mm_u_b), .load(cd_load),
    .load_val(entry_buf[15:12]),
    .q(mm_t_q), .nxt(mm_t_n), .carry(mm_t_c), .borrow(mm_t_b));

  logic unused_sink;
  assign unused_sink = ^{sec_u_q, sec_u_n, sec_t_q, sec_t_n, sec_u_b, sec_t_b, mn_u_b,
                         mn_t_b, hr_u_b, hr_t_b, hr_t_c, ss_u_c, ss_t_c, mm_u_c, mm_t_c,
                         mm_t_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_CLOCK;
      entry_buf <= 16'h0000;
    end else begin
      state     <= state_nxt;
      entry_buf <= buf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    buf_nxt   = entry_buf;
    tod_load  = 1'b0;
    cd_load   = 1'b0;
    run_dec   = 1'b0;
    case (state)
      ST_CLOCK: begin
        if (conf) begin
          state_nxt = ST_SET;
          buf_nxt   = {hr_t_q, hr_u_q, mn_t_q, mn_u_q};
        end else if (key_ok) begin
          state_nxt = ST_ENTRY;
          buf_nxt   = {12'h000, key_digit};
        end
      end
      ST_SET: begin
        if (cancel) begin
          state_nxt = ST_CLOCK;
        end else if (conf) begin
          state_nxt = ST_CLOCK;
          tod_load  = set_ok;
        end else if (key_ok) begin
          buf_nxt = {entry_buf[11:0], key_digit};
        end
      end
      ST_ENTRY: begin
        if (cancel) begin
          state_nxt = ST_CLOCK;
        end else if (start) begin
          if (entry_ok) begin
            state_nxt = ST_RUN;
            cd_load   = 1'b1;
          end
        end else if (key_ok) begin
          buf_nxt = {entry_buf[11:0], key_digit};
        end
      end
      ST_RUN: begin
        // A cancel in a tick cycle pauses without taking that second.
        if (cancel) begin
          state_nxt = ST_PAUSE;
        end else if (tick) begin
          run_dec = 1'b1;
          if (cd_one) state_nxt = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (cancel) begin
          state_nxt = ST_CLOCK;
          buf_nxt   = 16'h0000;
        end else if (start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (cancel || start || key_ok) state_nxt = ST_CLOCK;
      end
      default: state_nxt = ST_CLOCK;
    endcase
  end

  always_comb begin
    disp_nxt = 16'h0000;
    case (state_nxt)
      ST_CLOCK:           disp_nxt = {hr_t_n, hr_u_n, mn_t_n, mn_u_n};
      ST_SET, ST_ENTRY:   disp_nxt = buf_nxt;
      ST_RUN, ST_PAUSE:   disp_nxt = {mm_t_n, mm_u_n, ss_t_n, ss_u_n};
      default:            disp_nxt = 16'h0000;
    endcase
  end

  assign blink_st = (state_nxt == ST_SET) || (state_nxt == ST_PAUSE) || (state_nxt == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      disp      <= 16'h0000;
      disp_en   <= 4'hF;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      blink_cnt <= (blink_cnt == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt + 1'b1;
      blink_ph  <= blink_nxt;
      disp      <= disp_nxt;
      disp_en   <= blink_st ? {4{blink_nxt}} : 4'hF;
      running   <= (state_nxt == ST_RUN);
      done      <= (state_nxt == ST_DONE) && (state != ST_DONE);
    end
  end

endmodule
